// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, cause codes,
// FSM state encodings and stall patterns.
package trap_ctrl_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_W_MEPC    = 3'd1;
  localparam logic [2:0] S_W_MCAUSE  = 3'd2;
  localparam logic [2:0] S_W_MSTATUS = 3'd3;
  localparam logic [2:0] S_R_MSTATUS = 3'd4;
  localparam logic [2:0] S_JUMP      = 3'd5;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL = 32'd11;
  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_SW    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  // bit 0 = PC hold ... bit 5 = WB hold
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EXE  = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_TRAP = 6'b000001;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MSIE     = 3;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

endpackage

// File: rtl/trap_ctrl_irq_prio.sv
// Combinational event priority encoder: mret > ecall > ext > sw > timer,
// gated by the qualification from the sequencer.
module irq_prio
  import trap_ctrl_pkg::*;
(
  input  logic        qual_i,
  input  logic        exe_mret_i,
  input  logic        exe_ecall_i,
  input  logic        irq_ext_i,
  input  logic        irq_sw_i,
  input  logic        irq_timer_i,
  input  logic        mie_global_i,
  input  logic        meie_i,
  input  logic        msie_i,
  input  logic        mtie_i,
  output logic        take_o,
  output logic        is_int_o,
  output logic        is_mret_o,
  output logic [31:0] cause_o
);

  always_comb begin
    take_o    = 1'b0;
    is_int_o  = 1'b0;
    is_mret_o = 1'b0;
    cause_o   = '0;
    if (qual_i) begin
      if (exe_mret_i) begin
        take_o    = 1'b1;
        is_mret_o = 1'b1;
      end else if (exe_ecall_i) begin
        take_o  = 1'b1;
        cause_o = CAUSE_ECALL;
      end else if (mie_global_i) begin
        if (irq_ext_i && meie_i) begin
          take_o   = 1'b1;
          is_int_o = 1'b1;
          cause_o  = CAUSE_EXT;
        end else if (irq_sw_i && msie_i) begin
          take_o   = 1'b1;
          is_int_o = 1'b1;
          cause_o  = CAUSE_SW;
        end else if (irq_timer_i && mtie_i) begin
          take_o   = 1'b1;
          is_int_o = 1'b1;
          cause_o  = CAUSE_TIMER;
        end
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Pipeline stall merge plus the trap/mret sequencer that writes mepc,
// mcause and mstatus through a dedicated CSR port and redirects the PC.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int VECTORED       = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      stallreq_id_i,
  input  logic                      stallreq_exe_i,
  input  logic                      stallreq_mem_i,
  input  logic                      irq_ext_i,
  input  logic                      irq_sw_i,
  input  logic                      irq_timer_i,
  input  logic [DATA_WIDTH-1:0]     mstatus_i,
  input  logic [DATA_WIDTH-1:0]     mie_i,
  input  logic [DATA_WIDTH-1:0]     mtvec_i,
  input  logic [DATA_WIDTH-1:0]     mepc_i,
  input  logic                      exe_valid_i,
  input  logic                      exe_ecall_i,
  input  logic                      exe_mret_i,
  input  logic [ADDR_WIDTH-1:0]     exe_inst_addr_i,
  output logic [5:0]                stall_o,
  output logic                      flush_interrupt_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [DATA_WIDTH-1:0]     csr_wdata_o,
  output logic                      redirect_o,
  output logic [ADDR_WIDTH-1:0]     redirect_pc_o,
  output logic                      busy_o
);

  function automatic logic [DATA_WIDTH-1:0] mstatus_on_trap(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r               = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mstatus_on_mret(input logic [DATA_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] r;
    r               = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

  logic [2:0]            state_q;
  logic                  idle;
  logic                  qual;
  logic                  take;
  logic                  is_int;
  logic                  is_mret;
  logic [31:0]           cause;
  logic [31:0]           cause_q;
  logic [ADDR_WIDTH-1:0] trap_base;
  logic [ADDR_WIDTH-1:0] trap_target;
  logic                  unused_ok;

  assign idle = (state_q == S_IDLE);
  assign qual = idle && exe_valid_i && !(stallreq_id_i || stallreq_exe_i || stallreq_mem_i);

  irq_prio u_irq_prio (
    .qual_i       (qual),
    .exe_mret_i   (exe_mret_i),
    .exe_ecall_i  (exe_ecall_i),
    .irq_ext_i    (irq_ext_i),
    .irq_sw_i     (irq_sw_i),
    .irq_timer_i  (irq_timer_i),
    .mie_global_i (mstatus_i[MSTATUS_MIE]),
    .meie_i       (mie_i[MIE_MEIE]),
    .msie_i       (mie_i[MIE_MSIE]),
    .mtie_i       (mie_i[MIE_MTIE]),
    .take_o       (take),
    .is_int_o     (is_int),
    .is_mret_o    (is_mret),
    .cause_o      (cause)
  );

  assign unused_ok = ^{mie_i[DATA_WIDTH-1:12], mie_i[10:8], mie_i[6:4], mie_i[2:0],
                       mtvec_i[1:0], is_int};

  always_comb begin
    stall_o = STALL_NONE;
    if (!idle)               stall_o = STALL_TRAP;
    else if (stallreq_mem_i) stall_o = STALL_MEM;
    else if (stallreq_exe_i) stall_o = STALL_EXE;
    else if (stallreq_id_i)  stall_o = STALL_ID;
  end

  // The trapped EXE instruction is squashed in its detect cycle.
  assign flush_interrupt_o = take || !idle;
  assign busy_o            = !idle;

  assign trap_base   = {mtvec_i[ADDR_WIDTH-1:2], 2'b00};
  assign trap_target = ((VECTORED != 0) && cause_q[31])
                       ? trap_base + {cause_q[ADDR_WIDTH-3:0], 2'b00}
                       : trap_base;

  // cause latch (data only, no reset)
  always_ff @(posedge clk_i) begin
    if (idle && take) cause_q <= cause;
  end

  // sequencer: registered CSR port and redirect
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      csr_we_o      <= 1'b0;
      csr_waddr_o   <= '0;
      csr_wdata_o   <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (take && is_mret) begin
            state_q     <= S_R_MSTATUS;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MSTATUS);
            csr_wdata_o <= mstatus_on_mret(mstatus_i);
          end else if (take) begin
            state_q     <= S_W_MEPC;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MEPC);
            csr_wdata_o <= DATA_WIDTH'(exe_inst_addr_i);
          end
        end
        S_W_MEPC: begin
          state_q     <= S_W_MCAUSE;
          csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MCAUSE);
          csr_wdata_o <= DATA_WIDTH'(cause_q);
        end
        S_W_MCAUSE: begin
          state_q     <= S_W_MSTATUS;
          csr_waddr_o <= CSR_ADDR_WIDTH'(CSR_MSTATUS);
          csr_wdata_o <= mstatus_on_trap(mstatus_i);
        end
        S_W_MSTATUS: begin
          state_q       <= S_JUMP;
          csr_we_o      <= 1'b0;
          redirect_o    <= 1'b1;
          redirect_pc_o <= trap_target;
        end
        S_R_MSTATUS: begin
          state_q       <= S_JUMP;
          csr_we_o      <= 1'b0;
          redirect_o    <= 1'b1;
          redirect_pc_o <= ADDR_WIDTH'(mepc_i);
        end
        S_JUMP: begin
          state_q    <= S_IDLE;
          redirect_o <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          csr_we_o   <= 1'b0;
          redirect_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a schedule-based reference model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sid, sexe, smem;
  logic        irq_ext, irq_sw, irq_timer;
  logic [31:0] mstatus, mie, mtvec, mepc;
  logic        exe_valid, exe_ecall, exe_mret;
  logic [31:0] exe_addr;

  logic [5:0]  stall0, stall1;
  logic        flush0, flush1, we0, we1, redir0, redir1, busy0, busy1;
  logic [11:0] waddr0, waddr1;
  logic [31:0] wdata0, wdata1, pc0, pc1;

  always #5 clk = ~clk;

  trap_ctrl #(.VECTORED(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .stallreq_id_i(sid), .stallreq_exe_i(sexe), .stallreq_mem_i(smem),
    .irq_ext_i(irq_ext), .irq_sw_i(irq_sw), .irq_timer_i(irq_timer),
    .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .exe_valid_i(exe_valid), .exe_ecall_i(exe_ecall), .exe_mret_i(exe_mret),
    .exe_inst_addr_i(exe_addr),
    .stall_o(stall0), .flush_interrupt_o(flush0),
    .csr_we_o(we0), .csr_waddr_o(waddr0), .csr_wdata_o(wdata0),
    .redirect_o(redir0), .redirect_pc_o(pc0), .busy_o(busy0)
  );

  trap_ctrl #(.VECTORED(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .stallreq_id_i(sid), .stallreq_exe_i(sexe), .stallreq_mem_i(smem),
    .irq_ext_i(irq_ext), .irq_sw_i(irq_sw), .irq_timer_i(irq_timer),
    .mstatus_i(mstatus), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc),
    .exe_valid_i(exe_valid), .exe_ecall_i(exe_ecall), .exe_mret_i(exe_mret),
    .exe_inst_addr_i(exe_addr),
    .stall_o(stall1), .flush_interrupt_o(flush1),
    .csr_we_o(we1), .csr_waddr_o(waddr1), .csr_wdata_o(wdata1),
    .redirect_o(redir1), .redirect_pc_o(pc1), .busy_o(busy1)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each cycle's expected registered outputs are a queue
  // entry; a taken event appends its whole sequence at once.
  typedef struct {
    bit        act;
    bit        we;
    bit [11:0] addr;
    bit [31:0] data;
    bit        redir;
    bit [31:0] pc0;
    bit [31:0] pc1;
  } ent_t;

  ent_t sched[$];
  ent_t cur;
  ent_t idle_e;
  bit   chk_en = 1'b0;

  function automatic void model_event(output bit tk, output bit mr, output bit [31:0] cs);
    tk = 1'b0; mr = 1'b0; cs = 32'h0;
    if (!cur.act && exe_valid && !(sid || sexe || smem)) begin
      if (exe_mret) begin
        tk = 1'b1; mr = 1'b1;
      end else if (exe_ecall) begin
        tk = 1'b1; cs = 32'd11;
      end else if (mstatus[3]) begin
        if (irq_ext && mie[11])        cs = 32'h8000000B;
        else if (irq_sw && mie[3])     cs = 32'h80000003;
        else if (irq_timer && mie[7])  cs = 32'h80000007;
        tk = (cs != 0);
      end
    end
  endfunction

  function automatic ent_t mk(bit we, bit [11:0] a, bit [31:0] d, bit rd, bit [31:0] p0, bit [31:0] p1);
    ent_t e;
    e.act = 1'b1; e.we = we; e.addr = a; e.data = d; e.redir = rd; e.pc0 = p0; e.pc1 = p1;
    return e;
  endfunction

  initial begin
    bit        tk, mr;
    bit [31:0] cs, ms, base, vec;
    bit [5:0]  es;
    forever begin
      @(negedge clk);
      model_event(tk, mr, cs);
      if (chk_en) begin
        if (cur.act)   es = 6'b000001;
        else if (smem) es = 6'b011111;
        else if (sexe) es = 6'b001111;
        else if (sid)  es = 6'b000111;
        else           es = 6'b000000;
        chk("m_stall0", stall0, es);
        chk("m_stall1", stall1, es);
        chk("m_flush0", flush0, tk | cur.act);
        chk("m_flush1", flush1, tk | cur.act);
        chk("m_busy0", busy0, cur.act);
        chk("m_busy1", busy1, cur.act);
        chk("m_we0", we0, cur.we);
        chk("m_we1", we1, cur.we);
        chk("m_redir0", redir0, cur.redir);
        chk("m_redir1", redir1, cur.redir);
        if (cur.we) begin
          chk("m_waddr0", waddr0, cur.addr);
          chk("m_waddr1", waddr1, cur.addr);
          chk("m_wdata0", wdata0, cur.data);
          chk("m_wdata1", wdata1, cur.data);
        end
        if (cur.redir) begin
          chk("m_pc0", pc0, cur.pc0);
          chk("m_pc1", pc1, cur.pc1);
        end
      end
      if (rst) begin
        sched.delete();
        cur    = idle_e;
        chk_en = 1'b1;
      end else begin
        if (tk && mr) begin
          ms = mstatus;
          ms[3] = mstatus[7];
          ms[7] = 1'b1;
          sched.push_back(mk(1'b1, 12'h300, ms, 1'b0, 32'h0, 32'h0));
          sched.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, mepc, mepc));
        end else if (tk) begin
          ms = mstatus;
          ms[7] = mstatus[3];
          ms[3] = 1'b0;
          base = mtvec & 32'hFFFF_FFFC;
          vec  = cs[31] ? base + 32'd4 * (cs & 32'h7FFF_FFFF) : base;
          sched.push_back(mk(1'b1, 12'h341, exe_addr, 1'b0, 32'h0, 32'h0));
          sched.push_back(mk(1'b1, 12'h342, cs, 1'b0, 32'h0, 32'h0));
          sched.push_back(mk(1'b1, 12'h300, ms, 1'b0, 32'h0, 32'h0));
          sched.push_back(mk(1'b0, 12'h000, 32'h0, 1'b1, base, vec));
        end
        if (sched.size() > 0) cur = sched.pop_front();
        else                  cur = idle_e;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    sid = 0; sexe = 0; smem = 0;
    irq_ext = 0; irq_sw = 0; irq_timer = 0;
    mstatus = 0; mie = 0; mtvec = 0; mepc = 0;
    exe_valid = 0; exe_ecall = 0; exe_mret = 0; exe_addr = 0;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    tick(); tick();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_stall", stall0, 6'b0);
    chk("rst_flush", flush0, 1'b0);
    chk("rst_we", we0, 1'b0);
    chk("rst_waddr", waddr0, 12'h0);
    chk("rst_wdata", wdata0, 32'h0);
    chk("rst_redir", redir0, 1'b0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_busy", busy0, 1'b0);
    tick();

    // stall merge
    sexe = 1; smem = 1;
    @(negedge clk); chk("stall_mem_exe", stall0, 6'b011111);
    tick(); sexe = 1; smem = 0;
    @(negedge clk); chk("stall_exe", stall0, 6'b001111);
    tick(); sexe = 0; sid = 1;
    @(negedge clk); chk("stall_id", stall0, 6'b000111);
    tick(); sid = 0;

    // external interrupt trap
    mstatus = 32'h8; mie = 32'h800; mtvec = 32'h200;
    irq_ext = 1; exe_valid = 1; exe_addr = 32'h100;
    @(negedge clk); chk("ext_flush", flush0, 1'b1); chk("ext_stall", stall0, 6'b0);
    tick(); irq_ext = 0; exe_valid = 0;
    @(negedge clk); chk("ext_mepc_a", waddr0, 12'h341); chk("ext_mepc_d", wdata0, 32'h100);
    chk("ext_t1_stall", stall0, 6'b000001);
    tick();
    @(negedge clk); chk("ext_mcause_a", waddr0, 12'h342); chk("ext_mcause_d", wdata0, 32'h8000000B);
    tick();
    @(negedge clk); chk("ext_mstatus_a", waddr0, 12'h300); chk("ext_mstatus_d", wdata0, 32'h80);
    tick();
    @(negedge clk); chk("ext_redir", redir0, 1'b1); chk("ext_pc", pc0, 32'h200);
    chk("ext_pc_vec", pc1, 32'h22C); chk("ext_t4_we", we0, 1'b0);
    tick();
    @(negedge clk); chk("ext_t5_busy", busy0, 1'b0); chk("ext_t5_redir", redir0, 1'b0);
    tick();

    // vectored timer interrupt
    mstatus = 32'h8; mie = 32'h80; irq_timer = 1; exe_valid = 1; exe_addr = 32'h40;
    @(negedge clk); chk("tmr_flush", flush0, 1'b1);
    tick(); irq_timer = 0; exe_valid = 0;
    repeat (3) tick();
    @(negedge clk); chk("tmr_pc_vec", pc1, 32'h21C); chk("tmr_pc", pc0, 32'h200);
    tick(); tick();

    // ecall wins over a simultaneous external interrupt
    mstatus = 32'h8; mie = 32'h800; irq_ext = 1; exe_ecall = 1; exe_valid = 1; exe_addr = 32'h80;
    @(negedge clk); chk("ecall_flush", flush0, 1'b1);
    tick(); exe_ecall = 0; exe_valid = 0;
    @(negedge clk); chk("ecall_mepc", wdata0, 32'h80);
    tick();
    @(negedge clk); chk("ecall_mcause", wdata0, 32'd11);
    repeat (3) tick();
    mstatus = 32'h80; exe_valid = 1;
    @(negedge clk); chk("ext_masked0", flush0, 1'b0);
    tick();
    @(negedge clk); chk("ext_masked1", flush0, 1'b0);
    tick(); mstatus = 32'h88;
    @(negedge clk); chk("ext_unmasked", flush0, 1'b1);
    tick(); exe_valid = 0;
    tick();
    @(negedge clk); chk("ext_late_cause", wdata0, 32'h8000000B);
    repeat (3) tick();
    irq_ext = 0;

    // mret
    mstatus = 32'h80; mepc = 32'h104; exe_mret = 1; exe_valid = 1;
    @(negedge clk); chk("mret_flush", flush0, 1'b1);
    tick(); exe_mret = 0; exe_valid = 0;
    @(negedge clk); chk("mret_we", we0, 1'b1); chk("mret_a", waddr0, 12'h300);
    chk("mret_d", wdata0, 32'h88);
    tick();
    @(negedge clk); chk("mret_redir", redir0, 1'b1); chk("mret_pc", pc0, 32'h104);
    tick();
    @(negedge clk); chk("mret_t3_busy", busy0, 1'b0);
    tick();

    // blocked events
    mstatus = 32'h8; mie = 32'h800; irq_ext = 1; exe_valid = 1; smem = 1;
    @(negedge clk); chk("blk_mem_flush", flush0, 1'b0); chk("blk_mem_stall", stall0, 6'b011111);
    tick(); smem = 0; exe_valid = 0;
    @(negedge clk); chk("blk_valid_flush", flush0, 1'b0); chk("blk_valid_busy", busy0, 1'b0);
    tick(); irq_ext = 0;

    // reset in the middle of a trap
    exe_ecall = 1; exe_valid = 1; exe_addr = 32'h300;
    @(negedge clk); chk("rm_flush", flush0, 1'b1);
    tick(); exe_ecall = 0; exe_valid = 0;
    tick(); rst = 1;
    @(negedge clk); chk("rm_t2_busy", busy0, 1'b1);
    tick(); rst = 0;
    @(negedge clk);
    chk("rm_we", we0, 1'b0); chk("rm_waddr", waddr0, 12'h0); chk("rm_wdata", wdata0, 32'h0);
    chk("rm_redir", redir0, 1'b0); chk("rm_pc", pc0, 32'h0); chk("rm_busy", busy0, 1'b0);
    chk("rm_stall", stall0, 6'b0); chk("rm_flush_after", flush0, 1'b0);
    tick();
    @(negedge clk); chk("rm_no_redir", redir0, 1'b0);
    tick();

    // randomized run; CSR inputs only change while the sequencer is idle
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      sid       = ($urandom_range(0, 5) == 0);
      sexe      = ($urandom_range(0, 5) == 0);
      smem      = ($urandom_range(0, 5) == 0);
      irq_ext   = ($urandom_range(0, 2) == 0);
      irq_sw    = ($urandom_range(0, 2) == 0);
      irq_timer = ($urandom_range(0, 2) == 0);
      exe_valid = ($urandom_range(0, 3) != 0);
      exe_ecall = ($urandom_range(0, 7) == 0);
      exe_mret  = ($urandom_range(0, 9) == 0);
      exe_addr  = $urandom();
      if (!cur.act) begin
        mstatus = $urandom();
        mie     = $urandom();
        mtvec   = $urandom();
        mepc    = $urandom();
      end
      tick();
    end
    rst = 0;
    clr_in();
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
